// File: rtl/ring_counter_gen_if.sv
// Control/status bundle for ring_counter_gen: step controls, parallel load and counter outputs.
interface ring_counter_gen_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CW = $clog2(2 * WIDTH);

    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic [CW-1:0]    step_cnt;
    logic             wrap;
    logic             err;

    // Controller side: drives step/load controls, observes the counter.
    modport master (
        output en, dir, mode, load, load_val,
        input  out, step_cnt, wrap, err
    );

    // Counter side.
    modport slave (
        input  en, dir, mode, load, load_val,
        output out, step_cnt, wrap, err
    );
endinterface

// File: rtl/ring_counter_gen.sv
// ring_counter_gen: WIDTH-bit ring (one-hot) / Johnson shift-sequence counter with direction,
// count enable, parallel load, position index and wrap pulse.
// Optional macro RING_COUNTER_GEN_SELF_CORRECT_EN: illegal states are replaced by the seed
// and flagged on err for one cycle; without it err is tied low and any state rotates as-is.
module ring_counter_gen #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned INIT_POS = WIDTH - 1
) (
    input  logic                clk,
    input  logic                rstn,
    ring_counter_gen_if.slave   bus
);
    localparam int unsigned      CW        = $clog2(2 * WIDTH);
    localparam logic [WIDTH-1:0] RING_SEED = WIDTH'(1) << INIT_POS;
    localparam logic [CW-1:0]    RING_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    JOHN_LAST = CW'(2 * WIDTH - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    last_pos;

    // Ring mode starts from a single set bit, Johnson mode from all zeros.
    function automatic logic [WIDTH-1:0] seed(input logic m);
        return m ? '0 : RING_SEED;
    endfunction

    assign last_pos = mode_q ? JOHN_LAST : RING_LAST;

`ifdef RING_COUNTER_GEN_SELF_CORRECT_EN
    logic             err_q, err_d;
    logic             illegal;
    logic [WIDTH-2:0] trans;

    // Legality: one-hot in ring mode, at most one adjacent-bit transition in Johnson mode.
    always_comb begin
        trans   = out_q[WIDTH-2:0] ^ out_q[WIDTH-1:1];
        illegal = 1'b0;
        if (mode_q) illegal = ($countones(trans) > 1);
        else        illegal = ($countones(out_q) != 1);
    end
`endif

    // Next-state: mode change > load > (self-correct) > step > hold.
    always_comb begin
        out_d  = out_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        mode_d = mode_q;
`ifdef RING_COUNTER_GEN_SELF_CORRECT_EN
        err_d  = 1'b0;
`endif
        if (bus.mode != mode_q) begin
            out_d  = seed(bus.mode);
            cnt_d  = '0;
            mode_d = bus.mode;
        end else if (bus.load) begin
            out_d = bus.load_val;
            cnt_d = '0;
`ifdef RING_COUNTER_GEN_SELF_CORRECT_EN
        end else if (illegal) begin
            out_d = seed(mode_q);
            cnt_d = '0;
            err_d = 1'b1;
`endif
        end else if (bus.en) begin
            if (bus.dir) begin
                out_d  = {out_q[WIDTH-2:0], out_q[WIDTH-1] ^ mode_q};
                cnt_d  = (cnt_q == '0) ? last_pos : cnt_q - CW'(1);
                wrap_d = (cnt_q == CW'(1));
            end else begin
                out_d  = {out_q[0] ^ mode_q, out_q[WIDTH-1:1]};
                cnt_d  = (cnt_q == last_pos) ? '0 : cnt_q + CW'(1);
                wrap_d = (cnt_q == last_pos);
            end
        end
    end

    // State register with synchronous active-low reset; reset seed follows the sampled mode.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_q  <= seed(bus.mode);
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            mode_q <= bus.mode;
        end else begin
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            mode_q <= mode_d;
        end
    end

`ifdef RING_COUNTER_GEN_SELF_CORRECT_EN
    // Illegal-state flag register.
    always_ff @(posedge clk) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.out      = out_q;
    assign bus.step_cnt = cnt_q;
    assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_ring_counter_gen.sv
// Directed-vector bench for ring_counter_gen (WIDTH=4, INIT_POS=3).
module tb_ring_counter_gen;
`ifdef RING_COUNTER_GEN_SELF_CORRECT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    typedef struct {
        logic       rstn;
        logic       en;
        logic       dir;
        logic       mode;
        logic       load;
        logic [3:0] lv;
        logic [3:0] eo;
        logic [2:0] ec;
        logic       ew;
        logic       ee;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    ring_counter_gen_if #(.WIDTH(4)) bus();

    ring_counter_gen #(.WIDTH(4), .INIT_POS(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic d, input logic m, input logic l,
                       input logic [3:0] lv, input logic [3:0] eo, input logic [2:0] ec,
                       input logic ew, input logic ee);
        vec_t v;
        v.rstn = r; v.en = e; v.dir = d; v.mode = m; v.load = l; v.lv = lv;
        v.eo = eo; v.ec = ec; v.ew = ew; v.ee = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] eo, input logic [2:0] ec,
                         input logic ew, input logic ee);
        n_tests++;
        if (bus.out !== eo || bus.step_cnt !== ec || bus.wrap !== ew || bus.err !== ee) begin
            n_fail++;
            $display("FAIL %s: got out=%b cnt=%0d wrap=%b err=%b, want out=%b cnt=%0d wrap=%b err=%b",
                     name, bus.out, bus.step_cnt, bus.wrap, bus.err, eo, ec, ew, ee);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic d, input logic m,
                         input logic l, input logic [3:0] lv);
        rstn = r; bus.en = e; bus.dir = d; bus.mode = m; bus.load = l; bus.load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps;
        rstn = 1'b0; bus.en = 1'b0; bus.dir = 1'b0; bus.mode = 1'b0;
        bus.load = 1'b0; bus.load_val = 4'b0000;

        //   rstn en dir mode load lv       out      cnt wrap err
        // Ring forward from reset
        add(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0000, 4'b0010, 2, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0000, 4'b0001, 3, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0000, 4'b1000, 0, 1, 0);
        // Ring reverse
        add(1, 1, 1, 0, 0, 4'b0000, 4'b0001, 3, 0, 0);
        add(1, 1, 1, 0, 0, 4'b0000, 4'b0010, 2, 0, 0);
        add(1, 1, 1, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
        add(1, 1, 1, 0, 0, 4'b0000, 4'b1000, 0, 1, 0);
        add(1, 0, 1, 0, 0, 4'b0000, 4'b1000, 0, 0, 0);
        // Mode change to Johnson mid-run, full Johnson period
        add(1, 1, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b1000, 1, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b1100, 2, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b1110, 3, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b1111, 4, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b0111, 5, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b0011, 6, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b0001, 7, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 1, 0);
        add(1, 1, 1, 1, 0, 4'b0000, 4'b0001, 7, 0, 0);
        // Back to ring; mode change beats load
        add(1, 1, 0, 0, 1, 4'b0110, 4'b1000, 0, 0, 0);
        // Enable gating and load
        add(1, 1, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
        add(1, 0, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
        add(1, 0, 0, 0, 0, 4'b0000, 4'b0100, 1, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0000, 4'b0010, 2, 0, 0);
        add(1, 1, 0, 0, 1, 4'b0010, 4'b0010, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
        // Illegal ring value
        add(1, 1, 0, 0, 1, 4'b1010, 4'b1010, 0, 0, 0);
        add(1, 1, 0, 0, 0, 4'b0000, SC ? 4'b1000 : 4'b0101, SC ? 3'd0 : 3'd1, 0, SC);
        add(1, 1, 0, 0, 0, 4'b0000, SC ? 4'b0100 : 4'b1010, SC ? 3'd1 : 3'd2, 0, 0);
        add(1, 0, 0, 0, 1, 4'b1010, 4'b1010, 0, 0, 0);
        add(1, 0, 0, 0, 0, 4'b0000, SC ? 4'b1000 : 4'b1010, 0, 0, SC);
        add(1, 1, 0, 0, 0, 4'b0000, SC ? 4'b0100 : 4'b0101, 1, 0, 0);
        // Reset mid-sequence beats load/en; reset in Johnson mode seeds zeros
        add(0, 1, 0, 0, 1, 4'b0110, 4'b1000, 0, 0, 0);
        add(0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 1, 0, 1, 0, 4'b0000, 4'b1000, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rstn, vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].load, vecs[i].lv);
            check($sformatf("vec%0d", i), vecs[i].eo, vecs[i].ec, vecs[i].ew, vecs[i].ee);
        end

        // Three full ring periods forward: exactly three one-cycle wrap pulses.
        drive(0, 0, 0, 0, 0, 4'b0000);
        check("seq_reset", 4'b1000, 0, 0, 0);
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 0, 0, 0, 4'b0000);
            if (bus.wrap === 1'b1) wraps++;
        end
        n_tests++;
        if (wraps != 3) begin
            n_fail++;
            $display("FAIL seq_wrap_count: got %0d, want 3", wraps);
        end
        check("seq_end", 4'b1000, 0, 1, 0);

        // Direction flips every step: no bubble, position bounces.
        drive(1, 1, 1, 0, 0, 4'b0000);
        check("flip0", 4'b0001, 3, 0, 0);
        drive(1, 1, 0, 0, 0, 4'b0000);
        check("flip1", 4'b1000, 0, 1, 0);
        drive(1, 1, 0, 0, 0, 4'b0000);
        check("flip2", 4'b0100, 1, 0, 0);
        drive(1, 1, 1, 0, 0, 4'b0000);
        check("flip3", 4'b1000, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
